// File: rtl/key_pulse_gen.sv
// rtl/key_pulse_gen.sv - Debounced active-low pushbutton to single-cycle count pulses with auto-repeat
`timescale 1ns/1ps
module key_pulse_gen #(
  parameter int CNT_W           = 26,
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter bit REPEAT_EN       = 1'b1,
  parameter int REPEAT_DELAY    = 25000000,
  parameter int REPEAT_PERIOD   = 5000000
) (
  input  logic clock,
  input  logic reset,
  input  logic key_n,
  input  logic enable,
  output logic pressed,
  output logic pulse
);

  typedef enum logic [2:0] {
    IDLE,
    DEB_PRESS,
    HELD,
    REPEAT,
    DEB_RELEASE
  } state_t;

  // Terminal counts are one less than the cycle counts: the sample that
  // starts a phase is itself the first counted sample.
  localparam logic [CNT_W-1:0] DEB_LAST    = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] DELAY_LAST  = CNT_W'(REPEAT_DELAY - 1);
  localparam logic [CNT_W-1:0] PERIOD_LAST = CNT_W'(REPEAT_PERIOD - 1);
  localparam logic [CNT_W-1:0] TIMER_MAX   = '1;

  logic             sync1_q, sync2_q;
  state_t           state_q, state_d;
  logic [CNT_W-1:0] timer_q, timer_d;
  logic [CNT_W-1:0] timer_inc;
  logic             pressed_q, pressed_d;
  logic             pulse_q, pulse_d;
  logic             key_up;

  assign key_up    = sync2_q;
  assign timer_inc = (timer_q == TIMER_MAX) ? timer_q : timer_q + CNT_W'(1);

  always_ff @(posedge clock) begin
    if (reset) begin
      sync1_q   <= 1'b1;
      sync2_q   <= 1'b1;
      state_q   <= IDLE;
      timer_q   <= '0;
      pressed_q <= 1'b0;
      pulse_q   <= 1'b0;
    end else begin
      sync1_q   <= key_n;
      sync2_q   <= sync1_q;
      state_q   <= state_d;
      timer_q   <= timer_d;
      pressed_q <= pressed_d;
      pulse_q   <= pulse_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    timer_d   = timer_q;
    pressed_d = pressed_q;
    pulse_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (!key_up) begin
          state_d = DEB_PRESS;
          timer_d = '0;
        end
      end
      DEB_PRESS: begin
        if (key_up) begin
          state_d = IDLE;
          timer_d = '0;
        end else if (timer_q == DEB_LAST) begin
          state_d   = HELD;
          timer_d   = '0;
          pressed_d = 1'b1;
          pulse_d   = enable;
        end else begin
          timer_d = timer_inc;
        end
      end
      HELD: begin
        if (key_up) begin
          state_d = DEB_RELEASE;
          timer_d = '0;
        end else if (REPEAT_EN && (timer_q == DELAY_LAST)) begin
          state_d = REPEAT;
          timer_d = '0;
          pulse_d = enable;
        end else begin
          timer_d = timer_inc;
        end
      end
      REPEAT: begin
        // Release is checked first so a coincident tick never pulses.
        if (key_up) begin
          state_d = DEB_RELEASE;
          timer_d = '0;
        end else if (timer_q == PERIOD_LAST) begin
          timer_d = '0;
          pulse_d = enable;
        end else begin
          timer_d = timer_inc;
        end
      end
      DEB_RELEASE: begin
        if (!key_up) begin
          state_d = HELD;
          timer_d = '0;
        end else if (timer_q == DEB_LAST) begin
          state_d   = IDLE;
          timer_d   = '0;
          pressed_d = 1'b0;
        end else begin
          timer_d = timer_inc;
        end
      end
      default: begin
        state_d   = IDLE;
        timer_d   = '0;
        pressed_d = 1'b0;
      end
    endcase
  end

  assign pressed = pressed_q;
  assign pulse   = pulse_q;

endmodule

// File: tb/tb_key_pulse_gen.sv
// tb/tb_key_pulse_gen.sv - Bench for key_pulse_gen: vector table, directed corner sequences, random stimulus vs reference model
`timescale 1ns/1ps
module tb_key_pulse_gen;

  localparam int DEB    = 4;
  localparam int DELAY  = 10;
  localparam int PERIOD = 3;

  logic clock = 1'b0;
  logic reset = 1'b1;
  logic key_n = 1'b1;
  logic enable = 1'b1;
  logic pressed_r, pulse_r;   // REPEAT_EN = 1
  logic pressed_n, pulse_n;   // REPEAT_EN = 0

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  always #5 clock = ~clock;

  key_pulse_gen #(.CNT_W(8), .DEBOUNCE_CYCLES(DEB), .REPEAT_EN(1'b1),
                  .REPEAT_DELAY(DELAY), .REPEAT_PERIOD(PERIOD)) dut_r (
    .clock(clock), .reset(reset), .key_n(key_n), .enable(enable),
    .pressed(pressed_r), .pulse(pulse_r));

  key_pulse_gen #(.CNT_W(8), .DEBOUNCE_CYCLES(DEB), .REPEAT_EN(1'b0),
                  .REPEAT_DELAY(DELAY), .REPEAT_PERIOD(PERIOD)) dut_n (
    .clock(clock), .reset(reset), .key_n(key_n), .enable(enable),
    .pressed(pressed_n), .pulse(pulse_n));

  // Reference model: index 0 tracks dut_r, index 1 tracks dut_n.
  // Debounce is a run-length of identical synchronised samples; repeats are
  // scheduled arithmetically from the cycle the held phase began.
  logic m_s1[2], m_s2[2], m_last[2], m_pressed[2], m_hold[2], m_pulse[2];
  int   m_run[2], m_hs[2];

  task automatic model_update(input logic kn, input logic en, input logic rst);
    logic s;
    int   d;
    cyc++;
    for (int i = 0; i < 2; i++) begin
      if (rst) begin
        m_s1[i] = 1'b1; m_s2[i] = 1'b1; m_last[i] = 1'b1; m_run[i] = 0;
        m_pressed[i] = 1'b0; m_hold[i] = 1'b0; m_pulse[i] = 1'b0; m_hs[i] = 0;
      end else begin
        s = m_s2[i];
        m_s2[i] = m_s1[i];
        m_s1[i] = kn;
        if (s == m_last[i]) m_run[i] = (m_run[i] < 100000) ? m_run[i] + 1 : m_run[i];
        else m_run[i] = 1;
        m_last[i] = s;
        m_pulse[i] = 1'b0;
        if (!m_pressed[i]) begin
          if (!s && m_run[i] >= DEB + 1) begin
            m_pressed[i] = 1'b1; m_hold[i] = 1'b1; m_hs[i] = cyc; m_pulse[i] = en;
          end
        end else if (s) begin
          m_hold[i] = 1'b0;
          if (m_run[i] >= DEB + 1) m_pressed[i] = 1'b0;
        end else if (!m_hold[i]) begin
          m_hold[i] = 1'b1; m_hs[i] = cyc;
        end else begin
          d = cyc - m_hs[i];
          if (i == 0 && d >= DELAY && ((d - DELAY) % PERIOD) == 0) m_pulse[i] = en;
        end
      end
    end
  endtask

  task automatic chk(input string name, input logic got, input logic exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s cyc=%0d got=%b exp=%b", name, cyc, got, exp);
    end
  endtask

  // One clock: drive at negedge, model at posedge, compare at next negedge.
  task automatic step(input logic kn, input logic en, input logic rst);
    key_n = kn; enable = en; reset = rst;
    @(posedge clock);
    model_update(kn, en, rst);
    @(negedge clock);
    chk("model_pressed_r", pressed_r, m_pressed[0]);
    chk("model_pulse_r",   pulse_r,   m_pulse[0]);
    chk("model_pressed_n", pressed_n, m_pressed[1]);
    chk("model_pulse_n",   pulse_n,   m_pulse[1]);
  endtask

  task automatic do_reset();
    step(1'b1, 1'b1, 1'b1);
    step(1'b1, 1'b1, 1'b1);
  endtask

  typedef struct {
    logic key_n;
    logic enable;
    logic exp_pressed;
    logic exp_pulse;
  } vec_t;

  vec_t vecs[17];

  initial begin
    logic kn, en;
    int   len;
    for (int i = 0; i < 17; i++) begin
      vecs[i].key_n       = (i <= 7) ? 1'b0 : 1'b1;
      vecs[i].enable      = 1'b1;
      vecs[i].exp_pressed = (i >= 6 && i < 14);
      vecs[i].exp_pulse   = (i == 6);
    end

    @(negedge clock);
    do_reset();
    chk("reset_pressed", pressed_r, 1'b0);
    chk("reset_pulse",   pulse_r,   1'b0);

    // Single press and release from the vector table.
    for (int e = 0; e < 17; e++) begin
      step(vecs[e].key_n, vecs[e].enable, 1'b0);
      chk("t2_pressed_r", pressed_r, vecs[e].exp_pressed);
      chk("t2_pulse_r",   pulse_r,   vecs[e].exp_pulse);
      chk("t2_pressed_n", pressed_n, vecs[e].exp_pressed);
      chk("t2_pulse_n",   pulse_n,   vecs[e].exp_pulse);
    end

    // Bounce shorter than the debounce window never registers.
    do_reset();
    for (int e = 0; e < 20; e++) begin
      kn = (e <= 2 || (e >= 4 && e <= 6)) ? 1'b0 : 1'b1;
      step(kn, 1'b1, 1'b0);
      chk("t3_pressed", pressed_r, 1'b0);
      chk("t3_pulse",   pulse_r,   1'b0);
    end

    // Long hold with auto-repeat; release coincides with a repeat tick.
    do_reset();
    for (int e = 0; e < 40; e++) begin
      kn = (e <= 28) ? 1'b0 : 1'b1;
      step(kn, 1'b1, 1'b0);
      chk("t4_pulse_r", pulse_r,
          (e == 6 || e == 16 || e == 19 || e == 22 || e == 25 || e == 28));
      chk("t4_pressed_r", pressed_r, (e >= 6 && e < 35));
      chk("t4_pulse_n",   pulse_n,   (e == 6));
      chk("t4_pressed_n", pressed_n, (e >= 6 && e < 35));
    end

    // enable low until edge 20: no catch-up pulses.
    do_reset();
    for (int e = 0; e < 40; e++) begin
      kn = (e <= 28) ? 1'b0 : 1'b1;
      en = (e > 20) ? 1'b1 : 1'b0;
      step(kn, en, 1'b0);
      chk("t5_pulse",   pulse_r,   (e == 22 || e == 25 || e == 28));
      chk("t5_pressed", pressed_r, (e >= 6 && e < 35));
    end

    // No repeat, with a one-cycle release glitch mid-hold.
    do_reset();
    for (int e = 0; e < 50; e++) begin
      kn = (e <= 39 && e != 20) ? 1'b0 : 1'b1;
      step(kn, 1'b1, 1'b0);
      chk("t6_pulse_n",   pulse_n,   (e == 6));
      chk("t6_pressed_n", pressed_n, (e >= 6 && e < 46));
    end

    // Randomised runs of key levels, enable changes and occasional resets.
    do_reset();
    en = 1'b1;
    kn = 1'b1;
    for (int seg = 0; seg < 250; seg++) begin
      kn  = ~kn;
      len = ($urandom_range(0, 3) == 0) ? $urandom_range(15, 50) : $urandom_range(1, 6);
      for (int c = 0; c < len; c++) begin
        if ($urandom_range(0, 15) == 0) en = ~en;
        step(kn, en, ($urandom_range(0, 399) == 0) ? 1'b1 : 1'b0);
      end
    end

    // Reset while the key is held, then a fresh press from the held key.
    for (int e = 0; e < 20; e++) step(1'b0, 1'b1, 1'b0);
    for (int e = 0; e < 3; e++) begin
      step(1'b0, 1'b1, 1'b1);
      chk("t1_rst_pressed", pressed_r, 1'b0);
      chk("t1_rst_pulse",   pulse_r,   1'b0);
    end
    for (int e = 0; e < 10; e++) begin
      step(1'b0, 1'b1, 1'b0);
      chk("t1_pulse",   pulse_r,   (e == 6));
      chk("t1_pressed", pressed_r, (e >= 6));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
